// File: rtl/gray_to_binary_tracker.sv
// gray_to_binary_tracker: synchronizes a Gray-coded bus, converts it to binary and tracks single steps
//   clk, rst    : rising-edge clock, synchronous active-high reset
//   en          : tracking enable; low drops back to acquisition
//   gray_in     : asynchronous WIDTH-bit Gray input
//   clr_err     : clears the sticky illegal-jump flag
//   bin_out     : registered binary reference, bin_valid marks an acquired sample
//   step_up/dn  : one-cycle pulses on a +1/-1 step (mod 2^WIDTH)
//   err         : sticky illegal-transition flag
//   pos         : wrapping two's-complement step count
module gray_to_binary_tracker #(
   parameter int WIDTH = 3,
   parameter int POS_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             clr_err,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic             step_up,
   output logic             step_dn,
   output logic             err,
   output logic [POS_W-1:0] pos
);
   typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;
   state_t state;
   logic [WIDTH-1:0] sync0, sync1, cur, up_ref, dn_ref;
   logic [1:0] fill;
   // each binary bit is the XOR of all Gray bits at or above it
   for (genvar k = 0; k < WIDTH; k++) begin : g_conv
      assign cur[k] = ^sync1[WIDTH-1:k];
   end
   assign up_ref = bin_out + WIDTH'(1);
   assign dn_ref = bin_out - WIDTH'(1);
   always_ff @(posedge clk) begin
      if (rst) begin
         sync0     <= '0;
         sync1     <= '0;
         bin_out   <= '0;
         bin_valid <= 1'b0;
         step_up   <= 1'b0;
         step_dn   <= 1'b0;
         err       <= 1'b0;
         pos       <= '0;
         fill      <= '0;
         state     <= INIT;
      end else begin
         sync0   <= gray_in;
         sync1   <= sync0;
         // after reset, hold off acquisition until the synchronizer carries real input
         fill    <= fill + 2'(fill != 2'd2);
         step_up <= 1'b0;
         step_dn <= 1'b0;
         if (clr_err) err <= 1'b0;
         if (!en) begin
            state     <= INIT;
            bin_valid <= 1'b0;
         end else begin
            case (state)
               INIT: if (fill == 2'd2) begin
                  bin_out   <= cur;
                  bin_valid <= 1'b1;
                  state     <= TRACK;
               end
               TRACK: if (cur == up_ref) begin
                  bin_out <= cur;
                  step_up <= 1'b1;
                  pos     <= pos + POS_W'(1);
               end else if (cur == dn_ref) begin
                  bin_out <= cur;
                  step_dn <= 1'b1;
                  pos     <= pos - POS_W'(1);
               end else if (cur != bin_out) begin
                  bin_out <= cur;
                  err     <= 1'b1;
                  state   <= FAULT;
               end
               FAULT: begin
                  bin_out <= cur;
                  if (clr_err) state <= TRACK;
               end
               default: state <= INIT;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// tb_gray_to_binary_tracker: directed plus random check of gray_to_binary_tracker against a reference model
module tb_gray_to_binary_tracker;
   localparam int W = 3;
   localparam int P = 8;
   localparam int M = 1 << W;
   localparam int PM = 1 << P;
   logic clk = 1'b0;
   logic rst, en, clr_err;
   logic [W-1:0] gray_in;
   logic [W-1:0] bin_out;
   logic bin_valid, step_up, step_dn, err;
   logic [P-1:0] pos;
   int total = 0;
   int bad = 0;
   int ups = 0;
   int m_bin, m_valid, m_up, m_dn, m_err, m_pos, m_mode, m_since;
   int q[$];
   always #5 clk = ~clk;
   gray_to_binary_tracker #(.WIDTH(W), .POS_W(P)) dut (
      .clk(clk), .rst(rst), .en(en), .gray_in(gray_in), .clr_err(clr_err),
      .bin_out(bin_out), .bin_valid(bin_valid), .step_up(step_up),
      .step_dn(step_dn), .err(err), .pos(pos)
   );
   function automatic int b2g(input int b);
      return b ^ (b >> 1);
   endfunction
   // decode by searching for the binary value whose Gray code matches
   function automatic int g2b(input int g);
      for (int b = 0; b < M; b++) if (b2g(b) == g) return b;
      return -1;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask
   // mode: 0 acquiring, 1 tracking, 2 faulted; q holds the Gray values seen by the synchronizer
   task automatic model(input logic r, input logic e, input logic c, input int g);
      int cur, d;
      if (r) begin
         q = '{0, 0};
         m_bin = 0; m_valid = 0; m_up = 0; m_dn = 0; m_err = 0; m_pos = 0; m_mode = 0; m_since = 0;
      end else begin
         cur = g2b(q[q.size()-2]);
         q.push_back(g);
         if (q.size() > 3) void'(q.pop_front());
         m_since++;
         m_up = 0;
         m_dn = 0;
         if (c) m_err = 0;
         if (!e) begin
            m_mode = 0;
            m_valid = 0;
         end else if (m_mode == 0) begin
            if (m_since >= 3) begin
               m_bin = cur; m_valid = 1; m_mode = 1;
            end
         end else if (m_mode == 1) begin
            d = (cur - m_bin + M) % M;
            if (d == 1) begin
               m_up = 1; m_pos = (m_pos + 1) % PM; m_bin = cur;
            end else if (d == M - 1) begin
               m_dn = 1; m_pos = (m_pos + PM - 1) % PM; m_bin = cur;
            end else if (d != 0) begin
               m_bin = cur; m_err = 1; m_mode = 2;
            end
         end else begin
            m_bin = cur;
            if (c) m_mode = 1;
         end
      end
   endtask
   task automatic tick(input logic r, input logic e, input logic c, input int b);
      rst = r; en = e; clr_err = c; gray_in = W'(b2g(b));
      @(posedge clk);
      model(r, e, c, b2g(b));
      #1;
      if (step_up) ups++;
      chk("bin_out", 32'(bin_out), 32'(m_bin));
      chk("bin_valid", 32'(bin_valid), 32'(m_valid));
      chk("step_up", 32'(step_up), 32'(m_up));
      chk("step_dn", 32'(step_dn), 32'(m_dn));
      chk("err", 32'(err), 32'(m_err));
      chk("pos", 32'(pos), 32'(m_pos));
      chk("one_pulse", 32'(step_up & step_dn), 32'd0);
   endtask
   task automatic drive(input int b, input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b1, 1'b0, b);
   endtask
   initial begin
      int rb, hold, gap, e, c;
      tick(1'b1, 1'b0, 1'b0, 0);
      tick(1'b1, 1'b0, 1'b0, 0);
      chk("rst_bin", 32'(bin_out), 32'd0);
      chk("rst_valid", 32'(bin_valid), 32'd0);
      chk("rst_pos", 32'(pos), 32'd0);
      // forward sweep through all eight codes
      ups = 0;
      for (int b = 0; b < M; b++) drive(b, 4);
      chk("sweep_ups", 32'(ups), 32'd7);
      chk("sweep_bin", 32'(bin_out), 32'd7);
      chk("sweep_pos", 32'(pos), 32'd7);
      chk("sweep_err", 32'(err), 32'd0);
      // latency and wrap 7 -> 0
      drive(0, 1);
      chk("lat_n", 32'(step_up), 32'd0);
      drive(0, 1);
      chk("lat_n1", 32'(step_up), 32'd0);
      drive(0, 1);
      chk("lat_n2_up", 32'(step_up), 32'd1);
      chk("lat_n2_bin", 32'(bin_out), 32'd0);
      chk("lat_pos8", 32'(pos), 32'd8);
      drive(7, 3);
      chk("wrap_dn", 32'(step_dn), 32'd1);
      chk("wrap_pos7", 32'(pos), 32'd7);
      for (int b = 6; b >= 0; b--) drive(b, 3);
      chk("down_pos0", 32'(pos), 32'd0);
      drive(7, 3);
      chk("pos_wrap", 32'(pos), 32'd255);
      // illegal jump and sticky error
      drive(0, 3);
      chk("pos_wrap_up", 32'(pos), 32'd0);
      drive(2, 3);
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_bin", 32'(bin_out), 32'd2);
      chk("ill_pos", 32'(pos), 32'd0);
      drive(1, 3);
      drive(2, 3);
      chk("fault_bin", 32'(bin_out), 32'd2);
      chk("fault_pos", 32'(pos), 32'd0);
      tick(1'b0, 1'b1, 1'b1, 2);
      chk("clr_err", 32'(err), 32'd0);
      drive(3, 3);
      chk("after_clr_up", 32'(step_up), 32'd1);
      chk("after_clr_pos", 32'(pos), 32'd1);
      // clear coinciding with an illegal jump
      drive(6, 3);
      chk("fault2_err", 32'(err), 32'd1);
      drive(1, 2);
      tick(1'b0, 1'b1, 1'b1, 1);
      chk("prio_err", 32'(err), 32'd0);
      chk("prio_bin", 32'(bin_out), 32'd1);
      drive(2, 3);
      chk("prio_up", 32'(step_up), 32'd1);
      // enable gap with re-acquire
      drive(3, 3);
      chk("gap_pos3", 32'(pos), 32'd3);
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b0, 1'b0, 6);
         chk("gap_valid", 32'(bin_valid), 32'd0);
      end
      drive(6, 1);
      chk("reacq_bin", 32'(bin_out), 32'd6);
      chk("reacq_valid", 32'(bin_valid), 32'd1);
      chk("reacq_pos", 32'(pos), 32'd3);
      chk("reacq_err", 32'(err), 32'd0);
      // reset in the middle of a fault
      drive(7, 3);
      drive(0, 3);
      drive(3, 3);
      chk("mf_err", 32'(err), 32'd1);
      chk("mf_pos", 32'(pos), 32'd5);
      tick(1'b1, 1'b1, 1'b0, 3);
      chk("mf_rst_err", 32'(err), 32'd0);
      chk("mf_rst_pos", 32'(pos), 32'd0);
      drive(3, 2);
      chk("refill_valid", 32'(bin_valid), 32'd0);
      drive(3, 1);
      chk("acq_valid", 32'(bin_valid), 32'd1);
      chk("acq_bin", 32'(bin_out), 32'd3);
      // random phase: mostly single steps, some jumps, enable gaps, clears and resets
      rb = 3; hold = 0; gap = 0;
      for (int n = 0; n < 800; n++) begin
         if (hold == 0) begin
            case ($urandom_range(0, 9))
               0, 1, 2, 3: rb = (rb + 1) % M;
               4, 5, 6:    rb = (rb + M - 1) % M;
               default:    rb = int'($urandom_range(0, M - 1));
            endcase
            hold = int'($urandom_range(1, 4));
         end
         hold--;
         if (gap > 0) gap--;
         else if (m_mode != 2 && $urandom_range(0, 39) == 0) gap = int'($urandom_range(1, 4));
         e = (gap > 0) ? 0 : 1;
         c = (m_mode == 2 && $urandom_range(0, 5) == 0) ? 1 : 0;
         tick(($urandom_range(0, 199) == 0), e[0], c[0], rb);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
